// File: rtl/apb_cmd_master.sv
// apb_cmd_master: APB4 master fed by a valid/ready command FIFO, results returned through a 2-entry response buffer.
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort transfers whose PREADY stays low for TIMEOUT_CYC ACCESS cycles.
module apb_cmd_master #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CMD_DEPTH   = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                busy,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned PTR_W  = $clog2(CMD_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;
  state_e state_q;

  logic              fifo_write_q [CMD_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_q  [CMD_DEPTH];
  logic [DATA_W-1:0] fifo_wdata_q [CMD_DEPTH];
  logic [STRB_W-1:0] fifo_strb_q  [CMD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cmd_cnt_q;
  logic              cmd_push;

  logic [DATA_W-1:0] rsp_rdata_q [2];
  logic              rsp_err_q   [2];
  logic              rsp_wr_q, rsp_rd_q;
  logic [1:0]        rsp_cnt_q, rsp_cnt_d;
  logic              rsp_push, rsp_pop;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              rsp_err_d;

  logic complete, abort, start;

  assign cmd_ready = (cmd_cnt_q != CNT_W'(CMD_DEPTH));
  assign cmd_push  = cmd_valid && cmd_ready;
  assign rsp_valid = (rsp_cnt_q != 2'd0);
  assign rsp_rdata = rsp_rdata_q[rsp_rd_q];
  assign rsp_err   = rsp_err_q[rsp_rd_q];
  assign busy      = (cmd_cnt_q != '0) || (state_q != IDLE) || rsp_valid;

`ifdef APB_MASTER_TIMEOUT_EN
  logic [15:0] tmo_q;
  logic        rsp_tmo_q [2];

  assign abort       = (state_q == ACCESS) && !PREADY && (tmo_q == 16'(TIMEOUT_CYC - 1));
  assign rsp_timeout = rsp_tmo_q[rsp_rd_q];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tmo_q <= '0;
    end else if (start) begin
      tmo_q <= '0;
    end else if ((state_q == ACCESS) && !PREADY) begin
      tmo_q <= tmo_q + 16'd1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_tmo_q[0] <= 1'b0;
      rsp_tmo_q[1] <= 1'b0;
    end else if (rsp_push) begin
      rsp_tmo_q[rsp_wr_q] <= abort;
    end
  end
`else
  assign abort       = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // Start is judged against the response occupancy after this edge, so a completion always has a free slot.
  always_comb begin
    complete    = (state_q == ACCESS) && PREADY;
    rsp_push    = complete || abort;
    rsp_pop     = rsp_valid && rsp_ready;
    rsp_cnt_d   = rsp_cnt_q + {1'b0, rsp_push} - {1'b0, rsp_pop};
    start       = (cmd_cnt_q != '0) && (rsp_cnt_d <= 2'd1) && ((state_q == IDLE) || complete);
    rsp_rdata_d = (complete && !PWRITE) ? PRDATA : '0;
    rsp_err_d   = complete ? PSLVERR : 1'b1;
  end

  always_ff @(posedge PCLK) begin
    if (cmd_push) begin
      fifo_write_q[wr_ptr_q] <= cmd_write;
      fifo_addr_q[wr_ptr_q]  <= cmd_addr;
      fifo_wdata_q[wr_ptr_q] <= cmd_wdata;
      fifo_strb_q[wr_ptr_q]  <= cmd_strb;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cmd_cnt_q <= '0;
    end else begin
      if (cmd_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (start)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cmd_cnt_q <= cmd_cnt_q + CNT_W'(cmd_push) - CNT_W'(start);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int unsigned i = 0; i < 2; i++) begin
        rsp_rdata_q[i] <= '0;
        rsp_err_q[i]   <= 1'b0;
      end
      rsp_wr_q  <= 1'b0;
      rsp_rd_q  <= 1'b0;
      rsp_cnt_q <= 2'd0;
    end else begin
      if (rsp_push) begin
        rsp_rdata_q[rsp_wr_q] <= rsp_rdata_d;
        rsp_err_q[rsp_wr_q]   <= rsp_err_d;
        rsp_wr_q              <= ~rsp_wr_q;
      end
      if (rsp_pop) rsp_rd_q <= ~rsp_rd_q;
      rsp_cnt_q <= rsp_cnt_d;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      PSTRB   <= '0;
    end else if (start) begin
      state_q <= SETUP;
      PSEL    <= 1'b1;
      PENABLE <= 1'b0;
      PWRITE  <= fifo_write_q[rd_ptr_q];
      PADDR   <= fifo_addr_q[rd_ptr_q];
      PWDATA  <= fifo_write_q[rd_ptr_q] ? fifo_wdata_q[rd_ptr_q] : '0;
      PSTRB   <= fifo_write_q[rd_ptr_q] ? fifo_strb_q[rd_ptr_q] : '0;
    end else begin
      unique case (state_q)
        SETUP: begin
          state_q <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (complete || abort) begin
            state_q <= IDLE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: stimulus queues expected responses, a monitor pops and compares on each handshake.
`timescale 1ns/1ps
module tb_apb_cmd_master;
  localparam int unsigned TMO = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PSLVERR;

  apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .CMD_DEPTH(4), .TIMEOUT_CYC(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];
  int   comp_q[$];
  int   cyc = 0;
  int   hang_cnt = 0;
  int   last_stall = 0;

  logic [31:0] rd_base = 32'h0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic [31:0] hang_addr = 32'hFFFF_FFFF;
  int          sl_wait = 0;
  int          wcnt = 0;

  // Slave: garbage on PRDATA/PSLVERR whenever PREADY is low, so only the completing cycle may be sampled.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE && PADDR != hang_addr && wcnt >= sl_wait) begin
      PREADY  = 1'b1;
      PRDATA  = rd_base ^ PADDR;
      PSLVERR = (PADDR == err_addr);
    end else begin
      PREADY  = 1'b0;
      PRDATA  = 32'hBAD0_BAD0;
      PSLVERR = 1'b1;
    end
    if (PSEL && PENABLE) wcnt++;
    else wcnt = 0;
  end

  always @(posedge PCLK) begin
    cyc++;
    if (PSEL && PENABLE && PREADY) comp_q.push_back(cyc);
    if (PSEL && PENABLE && !PREADY && PADDR == hang_addr) hang_cnt++;
  end

  rsp_t prev_rsp;
  logic prev_stall = 1'b0;
  always @(negedge PCLK) begin
    rsp_t got, e;
    got = '{rdata: rsp_rdata, err: rsp_err, tmo: rsp_timeout};
    if (prev_stall) begin
      checks++;
      if (!rsp_valid || got != prev_rsp) begin
        errors++;
        $display("FAIL rsp_hold: got valid=%b %h required valid=1 %h", rsp_valid, got, prev_rsp);
      end
    end
    prev_stall = rsp_valid && !rsp_ready && PRESETn;
    prev_rsp   = got;
    if (rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b tmo=%b required no response", got.rdata, got.err, got.tmo);
      end else begin
        e = exp_q.pop_front();
        if (got != e) begin
          errors++;
          $display("FAIL rsp_compare: got rdata=%h err=%b tmo=%b required rdata=%h err=%b tmo=%b",
                   got.rdata, got.err, got.tmo, e.rdata, e.err, e.tmo);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] er, input logic ee, input logic et, input logic expect_rsp);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    while (!cmd_ready && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    last_stall = n;
    if (!cmd_ready) begin
      check("cmd_accept_bound", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge PCLK);
    if (expect_rsp) exp_q.push_back('{rdata: er, err: ee, tmo: et});
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 500) begin
      @(negedge PCLK);
      n++;
    end
    check(name, {busy, 31'd0, exp_q.size()}, 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  initial begin
    int k;
    int strb_bad, wdata_bad;
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge PCLK);
    check("reset_ctrl", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, busy}, 0);
    check("reset_bus", {PADDR, PWDATA} | {60'd0, PSTRB}, 0);
    check("reset_rdata", rsp_rdata, 0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("reset_cmd_ready", cmd_ready, 1);

    // Single write, zero-wait slave
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b0, 1'b1);
    @(posedge PCLK); #1;
    check("w_setup", {PSEL, PENABLE}, 2'b10);
    @(posedge PCLK); #1;
    check("w_access", {PSEL, PENABLE, PWRITE}, 3'b111);
    check("w_paddr", PADDR, 32'h10);
    check("w_pwdata", PWDATA, 32'hDEADBEEF);
    check("w_pstrb", PSTRB, 4'hF);
    @(posedge PCLK); #1;
    check("w_latency", rsp_valid, 1);
    wait_idle("w_idle");

    // Single read, two wait states
    rd_base = 32'hCAFEF00D ^ 32'h20;
    sl_wait = 2;
    strb_bad = 0; wdata_bad = 0;
    send(1'b0, 32'h20, 32'h12345678, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1);
    for (k = 1; k <= 20; k++) begin
      @(posedge PCLK); #1;
      if (PSEL && PSTRB != 4'h0) strb_bad++;
      if (PSEL && PWDATA != 32'h0) wdata_bad++;
      if (rsp_valid) break;
    end
    check("r_latency", k, 5);
    check("r_pstrb_zero", strb_bad, 0);
    check("r_pwdata_zero", wdata_bad, 0);
    sl_wait = 0;
    wait_idle("r_idle");

    // Back-to-back writes
    comp_q.delete();
    for (int i = 0; i < 5; i++)
      send(1'b1, 32'h60 + 32'(4 * i), 32'hA000 + 32'(i), 4'hF, 32'h0, 1'b0, 1'b0, 1'b1);
    check("b2b_5th_stall", last_stall, 0);
    wait_idle("b2b_idle");
    check("b2b_count", comp_q.size(), 5);
    for (int i = 1; i < 5 && i < comp_q.size(); i++)
      check("b2b_spacing", comp_q[i] - comp_q[i-1], 2);

    // Backpressure: responses held, FIFO fills, then drains in order
    rsp_ready = 1'b0;
    rd_base = 32'h11110000;
    comp_q.delete();
    for (int i = 0; i < 6; i++)
      send(1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'h0, 32'h11110100 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge PCLK);
    check("bp_third_not_started", PSEL, 0);
    check("bp_two_done", comp_q.size(), 2);
    check("bp_fifo_full", cmd_ready, 0);
    fork
      send(1'b0, 32'h118, 32'h0, 4'h0, 32'h11110118, 1'b0, 1'b0, 1'b1);
      begin
        repeat (3) @(posedge PCLK);
        #1;
        check("bp_still_full", cmd_ready, 0);
        check("bp_still_two", comp_q.size(), 2);
        rsp_ready = 1'b1;
      end
    join
    wait_idle("bp_idle");
    check("bp_all_done", comp_q.size(), 7);

    // Slave error
    err_addr = 32'h30;
    send(1'b1, 32'h30, 32'h55, 4'h3, 32'h0, 1'b1, 1'b0, 1'b1);
    wait_idle("err_idle");

`ifdef APB_MASTER_TIMEOUT_EN
    // Timeout on a hung slave, followed by a normal read
    hang_addr = 32'h40;
    hang_cnt = 0;
    send(1'b1, 32'h40, 32'h77, 4'hF, 32'h0, 1'b1, 1'b1, 1'b1);
    send(1'b0, 32'h44, 32'h0, 4'h0, 32'h11110044, 1'b0, 1'b0, 1'b1);
    wait_idle("tmo_idle");
    check("tmo_access_cycles", hang_cnt, TMO);
`endif

    // Asynchronous reset during a stalled ACCESS
    hang_addr = 32'h40;
    send(1'b1, 32'h40, 32'h99, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
    k = 0;
    while (!(PSEL && PENABLE) && k < 20) begin
      @(negedge PCLK);
      k++;
    end
    check("rst_reached_access", {PSEL, PENABLE}, 2'b11);
    @(posedge PCLK);
    #3 PRESETn = 1'b0;
    #1;
    check("rst_async_apb", {PSEL, PENABLE}, 2'b00);
    check("rst_async_busy", {busy, rsp_valid}, 2'b00);
    @(negedge PCLK);
    PRESETn = 1'b1;
    hang_addr = 32'hFFFF_FFFF;
    repeat (4) @(negedge PCLK);
    check("rst_no_response", {busy, rsp_valid}, 2'b00);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

Parametrised, synthesizable APB4 master that turns a valid/ready command stream into APB transfers and returns results on a valid/ready response stream. It is the successor to the single-transfer, task-driven APB master: a command FIFO buffers requests, back-to-back transfers run without returning to IDLE, and it adds PSTRB, error reporting and an optional PREADY timeout. It sits between an on-chip requester (CPU bridge, DMA, test sequencer) and the APB slave fabric.

## Interface
- ADDR_W, 32: PADDR / cmd_addr width.
- DATA_W, 32: data width; legal values 8, 16, 32. Strobe width is DATA_W/8.
- CMD_DEPTH, 4: command FIFO entries; power of two, at least 2.
- TIMEOUT_CYC, 16: ACCESS cycles with PREADY low before abort; 2..65535. Used only with APB_MASTER_TIMEOUT_EN.

- PCLK  in  1  clock, rising edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid and ready are both high.
- cmd_write  in  1  1 write, 0 read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when valid and ready are both high.
- rsp_rdata  out  DATA_W  read data; 0 for writes and aborted transfers.
- rsp_err  out  1  PSLVERR sampled, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- busy  out  1  FIFO non-empty, transfer in flight, or response pending.
- PSEL, PENABLE, PWRITE  out  1  APB control.
- PADDR  out  ADDR_W; PWDATA  out  DATA_W; PSTRB  out  DATA_W/8.
- PRDATA  in  DATA_W; PREADY  in  1; PSLVERR  in  1.

## Operation
- Command FIFO: cmd_ready = not full. It is combinational from the count, so it is 1 out of reset. A push while full cannot occur.
- Response buffer: 2 entries, first-in first-out. rsp_* always shows the head entry.
- FSM states:
  - IDLE: PSEL=0, PENABLE=0.
  - SETUP: PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1.
- Start condition: the FIFO is non-empty and the response buffer holds at most one entry after this edge's push/pop. This guarantees room at completion.
- IDLE -> SETUP when the start condition holds. The FIFO head is popped, and PADDR, PWRITE, PWDATA and PSTRB are loaded from it.
- For reads, PWDATA=0 and PSTRB=0.
- SETUP -> ACCESS unconditionally.
- ACCESS with PREADY=1 completes the transfer and pushes a response:
  - rdata = PRDATA for reads, otherwise 0.
  - err = PSLVERR.
  - timeout = 0.
  - Next state is SETUP with the next command if the start condition holds (PSEL stays 1, PENABLE drops); otherwise IDLE.
- ACCESS with PREADY=0: hold all APB outputs stable.
- PSLVERR and PRDATA are sampled only in an ACCESS cycle where PREADY=1.
- PADDR, PWRITE, PWDATA and PSTRB hold their last values in IDLE.
- Responses are returned in command order.

## Timing
- Reset (asynchronous): all APB outputs 0, rsp_valid=0, rsp fields 0, busy=0, FSM in IDLE, both buffers emptied.
- Reset asserted mid-transfer drops PSEL/PENABLE immediately. The in-flight transfer yields no response.
- Latency with an idle master, empty FIFO, zero-wait slave and cmd accepted at edge 0:
  - SETUP after edge 1.
  - ACCESS after edge 2.
  - rsp_valid after edge 3.
- Each PREADY wait cycle adds one cycle.
- Back-to-back throughput: one transfer per 2 cycles while FIFO data is available and rsp_ready=1.
- rsp_valid, once high, holds with stable fields until rsp_ready is sampled high.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A counter runs in ACCESS and clears on entry to SETUP.
  - After TIMEOUT_CYC consecutive ACCESS cycles with PREADY=0, the transfer is abandoned at that edge: PSEL and PENABLE go to 0 and the FSM goes to IDLE.
  - The pushed response has rdata=0, err=1, timeout=1.
  - A PREADY=1 in the final counted cycle completes the transfer normally.
- Not defined:
  - The master waits for PREADY indefinitely.
  - rsp_timeout is tied 0 and no counter is synthesized.

## Test plan
- Single write: cmd {write, 0x10, 0xDEADBEEF, strb 0xF}, zero-wait slave. Required: PSEL/PENABLE/PSTRB=0xF on the bus; rsp after 3 cycles with err=0, rdata=0.
- Single read: cmd read 0x20; slave returns 0xCAFEF00D with 2 wait states. Required: rsp_rdata=0xCAFEF00D 5 cycles after acceptance; PSTRB=0 throughout.
- Back-to-back: 4 writes pushed in consecutive cycles, rsp_ready=1. Required: no IDLE between transfers; 4 in-order responses; the 5th push is stalled only while the FIFO is full.
- Backpressure: rsp_ready=0 with 3 reads queued. Required: two transfers complete, the third does not start until a response is popped; no response is lost.
- Error: slave asserts PSLVERR with PREADY on a write to 0x30. Required: rsp_err=1, rsp_timeout=0.
- Timeout (macro on, TIMEOUT_CYC=16), PREADY held 0. Required: PSEL drops after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1; next queued command proceeds. Also: PRESETn low mid-ACCESS clears PSEL asynchronously and busy=0.
